// File: rtl/rv_alu_seq.sv
// rv_alu_seq: registered RV32I ALU with valid/ready handshake.
// Define RV_ALU_MULDIV_EN to add iterative RV32M multiply/divide.
module rv_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [XLEN-1:0] base_res;
  logic [SHW-1:0]  sh;
  logic            accept;

  assign sh        = b[SHW-1:0];
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Single-cycle base ALU; unknown codes give zero
  always_comb begin
    base_res = '0;
    case (op)
      5'd0: base_res = a + b;
      5'd1: base_res = a - b;
      5'd2: base_res = a << sh;
      5'd3: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'd4: base_res = {{(XLEN-1){1'b0}}, a < b};
      5'd5: base_res = a ^ b;
      5'd6: base_res = a >> sh;
      5'd7: base_res = XLEN'($signed(a) >>> sh);
      5'd8: base_res = a | b;
      5'd9: base_res = a & b;
      default: base_res = '0;
    endcase
  end

`ifdef RV_ALU_MULDIV_EN
  logic [2*XLEN-1:0] p;
  logic [2*XLEN-1:0] nxt_p;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   m;
  logic [XLEN-1:0]   amag;
  logic [XLEN-1:0]   bmag;
  logic [XLEN-1:0]   q;
  logic [XLEN-1:0]   r;
  logic [XLEN-1:0]   m_res;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rs;
  logic [SHW-1:0]    cnt;
  logic [4:0]        mop;
  logic              neg;
  logic              neg_in;
  logic              sa;
  logic              sb;
  logic              is_m;
  logic              is_div;

  assign is_m   = (op >= 5'd10) && (op <= 5'd17);
  assign is_div = (op >= 5'd14);

  // Operand sign handling at accept
  always_comb begin
    sa     = 1'b0;
    sb     = 1'b0;
    neg_in = 1'b0;
    case (op)
      5'd11: begin
        sa     = a[XLEN-1];
        sb     = b[XLEN-1];
        neg_in = a[XLEN-1] ^ b[XLEN-1];
      end
      5'd12: begin
        sa     = a[XLEN-1];
        neg_in = a[XLEN-1];
      end
      5'd14: begin
        sa     = a[XLEN-1];
        sb     = b[XLEN-1];
        neg_in = (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
      end
      5'd16: begin
        sa     = a[XLEN-1];
        sb     = b[XLEN-1];
        neg_in = a[XLEN-1];
      end
      default: ;
    endcase
    amag = sa ? -a : a;
    bmag = sb ? -b : b;
  end

  // One shift-add or restoring-subtract step
  always_comb begin
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    rs  = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    if (mop >= 5'd14) begin
      if (rs >= {1'b0, m})
        nxt_p = {XLEN'(rs - {1'b0, m}), p[XLEN-2:0], 1'b1};
      else
        nxt_p = {rs[XLEN-1:0], p[XLEN-2:0], 1'b0};
    end else begin
      nxt_p = {sum, p[XLEN-1:1]};
    end
  end

  // Sign-corrected M result from the final step
  always_comb begin
    prod  = neg ? -nxt_p : nxt_p;
    q     = nxt_p[XLEN-1:0];
    r     = nxt_p[2*XLEN-1:XLEN];
    m_res = '0;
    case (mop)
      5'd10:               m_res = prod[XLEN-1:0];
      5'd11, 5'd12, 5'd13: m_res = prod[2*XLEN-1:XLEN];
      5'd14, 5'd15:        m_res = neg ? -q : q;
      default:             m_res = neg ? -r : r;
    endcase
  end
`endif

  // Handshake FSM and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
`ifdef RV_ALU_MULDIV_EN
      p      <= '0;
      m      <= '0;
      cnt    <= '0;
      mop    <= '0;
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        BUSY: begin
`ifdef RV_ALU_MULDIV_EN
          p   <= nxt_p;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            result <= m_res;
            state  <= DONE;
          end
`else
          state <= IDLE;
`endif
        end
        default: begin
          if (accept) begin
`ifdef RV_ALU_MULDIV_EN
            if (is_m) begin
              mop   <= op;
              neg   <= neg_in;
              cnt   <= '0;
              state <= BUSY;
              if (is_div) begin
                p <= {{XLEN{1'b0}}, amag};
                m <= bmag;
              end else begin
                p <= {{XLEN{1'b0}}, bmag};
                m <= amag;
              end
            end else
`endif
            begin
              result <= base_res;
              state  <= DONE;
            end
          end else if (state != DONE || out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rv_alu_seq.md
# rv_alu_seq

Parametrised, handshaked successor to the RV32I combinational ALU. It registers the result behind a valid/ready interface and masks shift amounts to log2(XLEN) bits per the RISC-V spec. Unknown opcodes are defined to return zero. It optionally adds iterative RV32M multiply/divide. It sits between the decode/register-read stage and writeback, and can stall the pipeline via `in_ready`.

## Interface
- `XLEN`, default 32: operand/result width; power of two, 8..64.
- `SHW`, default $clog2(XLEN): shift-amount width; derived, not overridden.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `op` in 5: operation code.
- `a` in XLEN: operand 1 (rs1 value).
- `b` in XLEN: operand 2 (rs2 value or immediate).
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer takes result when `out_valid && out_ready`.
- `result` out XLEN: registered result.

## Operation
- Base ops:
  - 0 ADD, 1 SUB.
  - 2 SLL: `a << b[SHW-1:0]`.
  - 3 SLT: signed compare, 1/0.
  - 4 SLTU: unsigned compare, 1/0.
  - 5 XOR.
  - 6 SRL: logical, `b[SHW-1:0]`.
  - 7 SRA: arithmetic, sign-filled, `b[SHW-1:0]`.
  - 8 OR, 9 AND.
- M ops (macro only):
  - 10 MUL: low XLEN bits.
  - 11 MULH: signed×signed, high half.
  - 12 MULHSU: signed a × unsigned b, high half.
  - 13 MULHU: unsigned×unsigned, high half.
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
- All other op values return 0 with base latency.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. On accept, a base op computes directly into `result` and goes to DONE. An M op latches operands (magnitudes plus sign flags), clears the counter, and goes to BUSY.
  - BUSY: `in_ready`=0. Exactly one shift-add (multiply) or restoring-subtract (divide) step per cycle for XLEN cycles. On the last step, writes the sign-corrected result and goes to DONE.
  - DONE: `out_valid`=1, and `result` is held stable until `out_ready`.
    - `out_ready`=1 with `in_valid`=1: the new request is accepted in the same cycle (`in_ready` = `out_ready`) and dispatched as in IDLE.
    - `out_ready`=1 with no new request: go to IDLE.
- Division corner cases:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = most-negative, b = −1): DIV → a; REM → 0. Both use the normal XLEN-cycle latency.
- Arithmetic wraps modulo 2^XLEN; no flags.
- Products use a 2·XLEN accumulator. For signed ops, negate the result when the operand signs differ. A remainder takes the sign of a.
- Operands are sampled only at accept. Changes on `a`, `b` or `op` afterwards have no effect.

## Timing
- Reset (async assert, sync-released use at next edge):
  - state=IDLE, `out_valid`=0, `result`=0, counter=0, operand registers=0.
  - `in_ready`=1 immediately after reset.
- Base op accepted at edge N: `out_valid`=1 after edge N+1.
- M op accepted at edge N: `out_valid`=1 after edge N+XLEN+1.
- Back-to-back base ops with `out_ready` held at 1: one result per cycle.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from `in_valid` to any output.
- `rst_n` asserted mid-BUSY or mid-DONE: the operation is abandoned, outputs return to reset values, and no result is emitted.

## Configuration
- `RV_ALU_MULDIV_EN` defined: M ops 10–17, BUSY state, counter and accumulator are compiled in.
- Undefined: no BUSY logic. Ops 10–17 behave as unknown opcodes (result 0, 1-cycle latency). Area is the base ALU plus handshake registers only.

## Test plan
- Reset then ADD with a=0x7FFFFFFF, b=1, out_ready=1: `result`=0x80000000, `out_valid` high one cycle after accept. Then SUB with a=0, b=1: 0xFFFFFFFF.
- SRA with a=0x80000000, b=0x00000021 (shift masked to 1): 0xC0000000. SLT with a=0xFFFFFFFF, b=1: 1. SLTU with the same operands: 0. Op 31: 0.
- Backpressure: ADD completes with `out_ready`=0 for 5 cycles. `result` and `out_valid` are held and `in_ready`=0. Raising `out_ready` with a queued XOR accepts it in the same cycle.
- (`RV_ALU_MULDIV_EN`) MULH with a=0xFFFFFFFF, b=0xFFFFFFFF: 0x00000000. MULHU with the same operands: 0xFFFFFFFE. `out_valid` arrives exactly 33 cycles after accept.
- (`RV_ALU_MULDIV_EN`) Division:
  - DIV a=−7, b=2: 0xFFFFFFFD. REM with the same operands: 0xFFFFFFFF.
  - DIVU a=5, b=0: 0xFFFFFFFF. REMU with the same operands: 5.
  - DIV a=0x80000000, b=0xFFFFFFFF: 0x80000000.
- Assert `rst_n` at cycle 10 of a DIV: `out_valid` stays 0 and state is IDLE. A following ADD 2+3 returns 5 normally.
